// File: rtl/loop_nest_counter.sv
// Multi-level nested loop counter: level 0 is innermost and carries outward.
// Optional shadow limit registers enabled by defining LOOP_CNT_SHADOW_EN.
module loop_nest_counter #(
    parameter int BIT_WIDTH = 4,
    parameter int LEVELS    = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_inc,
    input  logic                        i_clear,
    input  logic [LEVELS*BIT_WIDTH-1:0] i_max_count,
    output logic [LEVELS*BIT_WIDTH-1:0] o_out,
    output logic [LEVELS-1:0]           o_terminal,
    output logic                        o_done,
    output logic                        o_wrap_pulse
);

    logic [LEVELS*BIT_WIDTH-1:0] r_count;
    logic                        r_wrap;
    logic [LEVELS*BIT_WIDTH-1:0] w_limit;
    logic [LEVELS*BIT_WIDTH-1:0] w_next;
    logic [LEVELS-1:0]           w_step;

`ifdef LOOP_CNT_SHADOW_EN
    logic [LEVELS*BIT_WIDTH-1:0] r_limit;

    // Limits are captured only at the start of an instruction.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_limit <= '0;
        end else if (i_clear) begin
            r_limit <= i_max_count;
        end
    end

    assign w_limit = r_limit;
`else
    assign w_limit = i_max_count;
`endif

    // >= so that a limit lowered below the current count wraps on the next step.
    genvar g;
    generate
        for (g = 0; g < LEVELS; g++) begin : g_term
            assign o_terminal[g] = (r_count[g*BIT_WIDTH +: BIT_WIDTH] >= w_limit[g*BIT_WIDTH +: BIT_WIDTH]);
        end
    endgenerate

    assign o_done = &o_terminal;

    always_comb begin
        w_step    = '0;
        w_step[0] = i_inc;
        for (int i = 1; i < LEVELS; i++) begin
            w_step[i] = w_step[i-1] & o_terminal[i-1];
        end
    end

    always_comb begin
        w_next = r_count;
        for (int i = 0; i < LEVELS; i++) begin
            if (w_step[i]) begin
                if (o_terminal[i]) begin
                    w_next[i*BIT_WIDTH +: BIT_WIDTH] = '0;
                end else begin
                    w_next[i*BIT_WIDTH +: BIT_WIDTH] = r_count[i*BIT_WIDTH +: BIT_WIDTH] + BIT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else if (i_clear) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_next;
            r_wrap  <= i_inc & o_done;
        end
    end

    assign o_out        = r_count;
    assign o_wrap_pulse = r_wrap;

endmodule

// File: doc/loop_nest_counter.md
# loop_nest_counter

Parametrised multi-level nested loop counter for the controller, generalising the single-level wrap counter to `LEVELS` cascaded levels. Each level has its own programmable terminal value. Level 0 is the innermost loop and carries into the next level. The block produces per-level terminal flags, a nest-done flag and a registered wrap pulse, which the controller uses to sequence instruction loop nests.

## Interface
- `BIT_WIDTH`, default 4: width of each level's count and limit.
- `LEVELS`, default 3: number of nested levels; must be at least 1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `inc`  in  1  advance the nest by one innermost step.
- `clear`  in  1  synchronous start of a new instruction: zeroes all counts.
- `max_count`  in  `LEVELS*BIT_WIDTH`  terminal values; level i occupies bits `[i*BIT_WIDTH +: BIT_WIDTH]`.
- `out`  out  `LEVELS*BIT_WIDTH`  current counts, packed the same way as `max_count`.
- `terminal`  out  `LEVELS`  `terminal[i]` = level i has reached its limit (combinational).
- `done`  out  1  AND of all `terminal` bits (combinational).
- `wrap_pulse`  out  1  registered; high for exactly one cycle after a full-nest wrap.

## Operation
- **Limit per level.** `limit[i]` is the shadow register when `LOOP_CNT_SHADOW_EN` is defined, otherwise the live `max_count` slice.
- **Terminal flag.** `terminal[i] = (out[i] >= limit[i])`, an unsigned compare.
  - `>=` guarantees that a limit lowered below the current count wraps on the next step.
- **Carry chain.**
  - `step[0] = inc`.
  - `step[i] = inc & terminal[0] & … & terminal[i-1]`.
- **Per-level update when `step[i]` is high:**
  - if `terminal[i]`: `out[i] <= 0`;
  - else: `out[i] <= out[i] + 1`.
  - Levels with `step[i]` low hold their value.
- **Nest wrap.** A cycle with `inc & done` wraps every level to 0 simultaneously. `wrap_pulse` is high in the following cycle.
- **Priority (highest first):** `rst` > `clear` > `inc`.
  - `clear` zeroes every `out[i]` and suppresses `inc` in that cycle.
  - `clear` does not assert `wrap_pulse`.
- **No saturation.** Arithmetic is modulo 2^`BIT_WIDTH`. With a limit of 2^`BIT_WIDTH`-1, the level counts 0 … max, then wraps.
- **Limit of 0.** `terminal[i]` is permanently 1, so the level is transparent to the carry.

## Timing
- **Reset values:** `out` = 0; `wrap_pulse` = 0; shadow limits (if present) = 0.
  - Consequently, with shadow limits enabled, `terminal` is all-ones and `done` = 1 immediately after reset, until the first `clear`.
  - Without shadow limits, `terminal` and `done` follow live `max_count` from reset onward.
- **Latency.**
  - `out` updates one cycle after the `inc` edge.
  - `terminal` and `done` reflect `out` and `limit` in the same cycle.
  - `wrap_pulse` asserts one cycle after the wrapping `inc`.
- **Back-to-back `inc`** is supported every cycle.
  - Consecutive full-nest wraps (possible only when all limits are 0) give a continuously high `wrap_pulse`.
- **Asynchronous reset mid-count:** all state returns to its reset value immediately; no pending `wrap_pulse` survives.
- **`clear` with `inc` in the same cycle:** the result is `out` = 0 and `wrap_pulse` = 0 next cycle, even if `done` was 1.

## Configuration
- **`LOOP_CNT_SHADOW_EN` defined:**
  - Adds `LEVELS*BIT_WIDTH` shadow limit registers, loaded from `max_count` on any cycle with `clear`.
  - The new limits take effect the cycle after `clear`.
  - Changes on `max_count` outside `clear` cycles are ignored.
- **`LOOP_CNT_SHADOW_EN` undefined:**
  - No limit storage; `limit` is the live `max_count`.
  - The upstream decoder must hold `max_count` stable for the whole instruction.

## Test plan
All scenarios use `BIT_WIDTH`=2, `LEVELS`=2.

1. **Basic nest.** `max_count` = {1,2} (level1=1, level0=2), `clear`, then 6 `inc` cycles.
   - `out` pairs (L1,L0): (0,1),(0,2),(1,0),(1,1),(1,2),(0,0).
   - `done` is high while at (1,2); `wrap_pulse` is high one cycle after the 6th `inc`.
2. **Clear priority.** At (1,1), assert `clear`+`inc` together.
   - `out` = (0,0) next cycle; `wrap_pulse` stays 0.
3. **Zero limit transparency.** Limits {2,0} with continuous `inc`.
   - Level1 steps every cycle: 1,2,0; level0 stays 0.
   - `terminal[0]` = 1 throughout; `wrap_pulse` once per 3 `inc`.
4. **Shadow behaviour.**
   - With `LOOP_CNT_SHADOW_EN`: load {3,3} via `clear`, change `max_count` to {0,0} without `clear`, then 4 `inc`. Result: `out` = (1,0); `done` = 0.
   - Without the macro: the same stimulus gives a wrap on the 1st `inc` (`out` ≥ limit) and `wrap_pulse` next cycle.
5. **Async reset mid-count.** At (1,2) with `wrap_pulse` pending, pulse `rst` between clock edges.
   - `out` = 0 and `wrap_pulse` = 0 immediately.
   - With shadow enabled, `done` = 1 (limits 0).
6. **Full-range wrap.** Limits {3,3}, 16 `inc` from (0,0).
   - Sequence visits all 16 states, returns to (0,0), and gives exactly one `wrap_pulse`.
